time_of_day_counter: RTL and testbench

//   Free-running 24 h time-of-day counter: seconds, minutes and hours.

---
 rtl/tod_pkg.sv | 27 ++
 rtl/time_of_day_counter_if.sv | 43 ++++
 rtl/sec_prescaler.sv | 30 +++
 rtl/time_of_day_counter.sv | 105 ++++++++++
 tb/tb_time_of_day_counter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/tod_pkg.sv
// rtl/tod_pkg.sv - shared widths, field limits, time record and wrap helpers for the time-of-day counter
package tod_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  SEC_MAX  = 6'd59;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [MIN_W-1:0]  sec;
    } tod_t;

    function automatic logic tod_legal(input tod_t t);
        return (t.hour <= HOUR_MAX) && (t.min <= MIN_MAX) && (t.sec <= SEC_MAX);
    endfunction

    // Hours ride through this too, zero-extended to the wider field.
    function automatic logic [MIN_W-1:0] inc_wrap(input logic [MIN_W-1:0] v,
                                                   input logic [MIN_W-1:0] max);
        return (v == max) ? '0 : v + MIN_W'(1);
    endfunction

endpackage

// File: rtl/time_of_day_counter_if.sv
// rtl/time_of_day_counter_if.sv - control/status bundle of the time-of-day counter; alarm signals under TOD_ALARM_EN
interface time_of_day_counter_if;
    import tod_pkg::*;

    logic              run;
    logic              set_valid;
    logic [HOUR_W-1:0] set_hour;
    logic [MIN_W-1:0]  set_min;
    logic [MIN_W-1:0]  set_sec;
    logic              inc_min;
    logic              inc_hour;
    logic [HOUR_W-1:0] hour24;
    logic [MIN_W-1:0]  min;
    logic [MIN_W-1:0]  sec;
    logic              sec_tick;
    logic              day_wrap;
    logic              set_err;
`ifdef TOD_ALARM_EN
    logic              alarm_on;
    logic [HOUR_W-1:0] alarm_hour;
    logic [MIN_W-1:0]  alarm_min;
    logic              alarm;
`endif

    modport master (
        output run, set_valid, set_hour, set_min, set_sec, inc_min, inc_hour,
`ifdef TOD_ALARM_EN
        output alarm_on, alarm_hour, alarm_min,
        input  alarm,
`endif
        input  hour24, min, sec, sec_tick, day_wrap, set_err
    );

    modport slave (
        input  run, set_valid, set_hour, set_min, set_sec, inc_min, inc_hour,
`ifdef TOD_ALARM_EN
        input  alarm_on, alarm_hour, alarm_min,
        output alarm,
`endif
        output hour24, min, sec, sec_tick, day_wrap, set_err
    );

endinterface

// File: rtl/sec_prescaler.sv
// rtl/sec_prescaler.sv - divides clk down to a one-per-second advance strobe
module sec_prescaler #(
    parameter int CLK_PER_SEC = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_PER_SEC);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_PER_SEC - 1);

    logic [CNT_W-1:0] count;

    // Combinational: true in the cycle whose closing edge wraps the count.
    assign tick = run && (count == TERM);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= (count == TERM) ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/time_of_day_counter.sv
// rtl/time_of_day_counter.sv - 24 h hh:mm:ss counter with load/adjust; TOD_ALARM_EN adds the hh:mm alarm
module time_of_day_counter
    import tod_pkg::*;
#(
    parameter int CLK_PER_SEC = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    time_of_day_counter_if.slave  bus
);

    tod_t cur;
    tod_t nxt;
    tod_t set_val;
    logic set_ok;
    logic set_bad;
    logic tick;
    logic adv;
    logic sec_wrap;
    logic min_wrap;
    logic day_wrap_n;
    logic sec_tick_q;
    logic day_wrap_q;
    logic set_err_q;

    assign set_val = {bus.set_hour, bus.set_min, bus.set_sec};
    assign set_ok  = bus.set_valid && tod_legal(set_val);
    assign set_bad = bus.set_valid && !set_ok;

    sec_prescaler #(.CLK_PER_SEC(CLK_PER_SEC)) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .run   (bus.run),
        .clear (set_ok),
        .tick  (tick)
    );

    always_comb begin
        nxt        = cur;
        adv        = 1'b0;
        sec_wrap   = 1'b0;
        min_wrap   = 1'b0;
        day_wrap_n = 1'b0;
        if (set_ok) begin
            nxt = set_val;
        end else if (!bus.set_valid) begin
            adv      = tick;
            sec_wrap = tick && (cur.sec == SEC_MAX);
            if (tick) begin
                nxt.sec = inc_wrap(cur.sec, SEC_MAX);
            end
            // An adjusted field swallows any carry arriving from below.
            if (bus.inc_min || sec_wrap) begin
                nxt.min = inc_wrap(cur.min, MIN_MAX);
            end
            min_wrap = sec_wrap && !bus.inc_min && (cur.min == MIN_MAX);
            if (bus.inc_hour || min_wrap) begin
                nxt.hour = HOUR_W'(inc_wrap(MIN_W'(cur.hour), MIN_W'(HOUR_MAX)));
            end
            day_wrap_n = min_wrap && !bus.inc_hour && (cur.hour == HOUR_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= '0;
            sec_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            cur        <= nxt;
            sec_tick_q <= adv;
            day_wrap_q <= day_wrap_n;
            set_err_q  <= set_bad;
        end
    end

    assign bus.hour24   = cur.hour;
    assign bus.min      = cur.min;
    assign bus.sec      = cur.sec;
    assign bus.sec_tick = sec_tick_q;
    assign bus.day_wrap = day_wrap_q;
    assign bus.set_err  = set_err_q;

`ifdef TOD_ALARM_EN
    logic alarm_n;
    logic alarm_q;

    // Only a clock-driven advance may fire; manual adjustments landing on the match stay silent.
    assign alarm_n = adv && !bus.inc_min && !bus.inc_hour && bus.alarm_on &&
                     (nxt.hour == bus.alarm_hour) && (nxt.min == bus.alarm_min) &&
                     (nxt.sec == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_n;
        end
    end

    assign bus.alarm = alarm_q;
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// tb/tb_time_of_day_counter.sv - directed bench for time_of_day_counter at CLK_PER_SEC=4; alarm cases under TOD_ALARM_EN
module tb_time_of_day_counter;
    import tod_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n;
    int   seen;

    time_of_day_counter_if bus();

    time_of_day_counter #(.CLK_PER_SEC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check(tag, 32'(bus.hour24) * 10000 + 32'(bus.min) * 100 + 32'(bus.sec),
              32'(h * 10000 + m * 100 + s));
    endtask

    task automatic load(input int h, input int m, input int s);
        bus.set_hour  = 5'(h);
        bus.set_min   = 6'(m);
        bus.set_sec   = 6'(s);
        bus.set_valid = 1'b1;
        step();
        bus.set_valid = 1'b0;
    endtask

    task automatic wait_tick(input int limit, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!bus.sec_tick && cnt < limit);
        if (!bus.sec_tick) check("tick_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.run       = 1'b0;
        bus.set_valid = 1'b0;
        bus.set_hour  = '0;
        bus.set_min   = '0;
        bus.set_sec   = '0;
        bus.inc_min   = 1'b0;
        bus.inc_hour  = 1'b0;
`ifdef TOD_ALARM_EN
        bus.alarm_on   = 1'b0;
        bus.alarm_hour = '0;
        bus.alarm_min  = '0;
`endif
        step();
        step();
        check_time("reset_time", 0, 0, 0);
        check("reset_tick", bus.sec_tick, 32'd0);
        check("reset_day_wrap", bus.day_wrap, 32'd0);
        check("reset_set_err", bus.set_err, 32'd0);
        rst = 1'b0;

        // free run: tick on every 4th edge
        bus.run = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            check("t1_tick", bus.sec_tick, ((i + 1) % 4 == 0) ? 32'd1 : 32'd0);
            check("t1_sec", bus.sec, 32'((i + 1) / 4));
        end
        check("t1_hour", bus.hour24, 32'd0);
        check("t1_min", bus.min, 32'd0);

        // reset mid-count clears time and prescaler
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_time("rst_mid_time", 0, 0, 0);
        wait_tick(10, n);
        check("rst_mid_period", 32'(n), 32'd4);

        // day rollover
        load(23, 59, 58);
        check_time("t2_load", 23, 59, 58);
        wait_tick(10, n);
        check("t2_period1", 32'(n), 32'd4);
        check_time("t2_tick1", 23, 59, 59);
        check("t2_no_wrap", bus.day_wrap, 32'd0);
        wait_tick(10, n);
        check("t2_period2", 32'(n), 32'd4);
        check_time("t2_tick2", 0, 0, 0);
        check("t2_day_wrap", bus.day_wrap, 32'd1);
        step();
        check("t2_wrap_pulse", bus.day_wrap, 32'd0);

        // illegal loads
        bus.run = 1'b0;
        load(10, 20, 30);
        check("t3_legal_err", bus.set_err, 32'd0);
        load(24, 20, 30);
        check("t3_hour_err", bus.set_err, 32'd1);
        check_time("t3_hour_keep", 10, 20, 30);
        step();
        check("t3_err_pulse", bus.set_err, 32'd0);
        load(10, 60, 30);
        check("t3_min_err", bus.set_err, 32'd1);
        check_time("t3_min_keep", 10, 20, 30);
        load(10, 20, 60);
        check("t3_sec_err", bus.set_err, 32'd1);
        check_time("t3_sec_keep", 10, 20, 30);

        // inc_min coincident with a tick at 05:59:59
        bus.run = 1'b1;
        load(5, 59, 59);
        seen = 0;
        repeat (3) begin
            step();
            if (bus.sec_tick) seen++;
        end
        check("t4_early_ticks", 32'(seen), 32'd0);
        bus.inc_min = 1'b1;
        step();
        bus.inc_min = 1'b0;
        check("t4_tick", bus.sec_tick, 32'd1);
        check_time("t4_time", 5, 0, 0);
        check("t4_day_wrap", bus.day_wrap, 32'd0);

        // manual adjustments and loading while stopped
        bus.run = 1'b0;
        load(23, 10, 0);
        bus.inc_hour = 1'b1;
        step();
        bus.inc_hour = 1'b0;
        check_time("t5_inc_hour", 0, 10, 0);
        load(12, 59, 0);
        bus.inc_min = 1'b1;
        step();
        bus.inc_min = 1'b0;
        check_time("t5_inc_min", 12, 0, 0);
        load(23, 59, 0);
        bus.inc_min  = 1'b1;
        bus.inc_hour = 1'b1;
        step();
        bus.inc_min  = 1'b0;
        bus.inc_hour = 1'b0;
        check_time("t5_inc_both", 0, 0, 0);
        check("t5_both_wrap", bus.day_wrap, 32'd0);
        load(12, 0, 0);
        check_time("t5_load_stopped", 12, 0, 0);
        seen = 0;
        repeat (8) begin
            step();
            if (bus.sec_tick) seen++;
        end
        check("t5_no_ticks", 32'(seen), 32'd0);
        check_time("t5_frozen", 12, 0, 0);

`ifdef TOD_ALARM_EN
        bus.alarm_hour = 5'd7;
        bus.alarm_min  = 6'd30;
        bus.alarm_on   = 1'b1;
        bus.run        = 1'b1;
        load(7, 29, 58);
        wait_tick(10, n);
        check("t6_alarm_early", bus.alarm, 32'd0);
        wait_tick(10, n);
        check_time("t6_time", 7, 30, 0);
        check("t6_alarm", bus.alarm, 32'd1);
        step();
        check("t6_alarm_pulse", bus.alarm, 32'd0);
        bus.alarm_on = 1'b0;
        load(7, 29, 59);
        wait_tick(10, n);
        check_time("t6_off_time", 7, 30, 0);
        check("t6_alarm_off", bus.alarm, 32'd0);
        bus.alarm_on = 1'b1;
        bus.run      = 1'b0;
        load(7, 30, 0);
        check("t6_alarm_load", bus.alarm, 32'd0);
        load(7, 29, 0);
        bus.inc_min = 1'b1;
        step();
        bus.inc_min = 1'b0;
        check_time("t6_inc_time", 7, 30, 0);
        check("t6_alarm_inc", bus.alarm, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
